// File: rtl/regfile_pkg.sv
// Shared widths, typed constants and helpers for the general-purpose register file.
// Optional same-cycle write-to-read forwarding is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned REG_W        = 32;
    localparam int unsigned REG_NUM      = 32;
    localparam int unsigned REG_NUM_LOG2 = 5;

    typedef logic [REG_ADDR_W-1:0]           reg_addr_t;
    typedef logic [REG_W-1:0]                reg_word_t;
    typedef logic [REG_NUM-1:0][REG_W-1:0]   reg_array_t;

    localparam reg_word_t ZERO_WORD     = 32'h0000_0000;
    localparam reg_addr_t NOP_REG_ADDR  = 5'd0;
    localparam logic      WRITE_ENABLE  = 1'b1;
    localparam logic      WRITE_DISABLE = 1'b0;
    localparam logic      READ_ENABLE   = 1'b1;
    localparam logic      READ_DISABLE  = 1'b0;

    // A write only lands when enabled and aimed at a real (non-zero) register.
    function automatic logic write_commits(input logic we, input reg_addr_t waddr);
        return (we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR);
    endfunction

endpackage

// File: rtl/regfile_rport.sv
// One combinational read port: reset, enable, r0 and (with REGFILE_BYPASS_EN) forwarding priority.
module regfile_rport
    import regfile_pkg::*;
(
    input  logic       rst,
    input  logic       re,
    input  reg_addr_t  raddr,
    input  reg_array_t regs,
    input  logic       we,
    input  reg_addr_t  waddr,
    input  reg_word_t  wdata,
    output reg_word_t  rdata
);

`ifndef REGFILE_BYPASS_EN
    logic unused_wport_s;
    assign unused_wport_s = ^{we, waddr, wdata};
`endif

    // Read mux, highest priority first.
    always_comb begin
        rdata = ZERO_WORD;
        if (rst == 1'b0) begin
            rdata = ZERO_WORD;
        end else if (re == READ_DISABLE) begin
            rdata = ZERO_WORD;
        end else if (raddr == NOP_REG_ADDR) begin
            rdata = ZERO_WORD;
`ifdef REGFILE_BYPASS_EN
        end else if ((we == WRITE_ENABLE) && (waddr == raddr)) begin
            rdata = wdata;
`endif
        end else begin
            rdata = regs[raddr];
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file with one write port and two independent combinational read ports.
// Define REGFILE_BYPASS_EN to forward the write-port data to a matching read in the same cycle.
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_word_t wdata,
    input  logic      re1,
    input  reg_addr_t raddr1,
    output reg_word_t rdata1,
    input  logic      re2,
    input  reg_addr_t raddr2,
    output reg_word_t rdata2
);

    reg_array_t regs_q;
    reg_array_t regs_d;

    // Next storage contents: r0 is never written, so it keeps its reset value of zero.
    always_comb begin
        regs_d = regs_q;
        if (write_commits(we, waddr)) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage register; reset clears every entry without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rport u_rport1 (
        .rst   (rst),
        .re    (re1),
        .raddr (raddr1),
        .regs  (regs_q),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata1)
    );

    regfile_rport u_rport2 (
        .rst   (rst),
        .re    (re2),
        .raddr (raddr2),
        .regs  (regs_q),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: array model checked every negedge plus directed literal checks.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [32];

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference storage: what the register array must hold.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'h0;
        end else if (we && (waddr != 5'd0)) begin
            model[waddr] <= wdata;
        end
    end

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
        if (!rst || !re || (a == 5'd0)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && (waddr == a)) return wdata;
`endif
        return model[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every negedge both ports must agree with the model.
    always @(negedge clk) begin
        chk("model_port1", rdata1, exp_read(re1, raddr1));
        chk("model_port2", rdata2, exp_read(re2, raddr2));
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = 5'd0;
        #1;
        chk("reset_read", rdata1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset clears immediately and stays clear after release.
        wr(5'd5, 32'h1234_5678);
        #1 chk("r5_written", rdata1, 32'h1234_5678);
        #1 rst = 1'b0;
        #1 chk("r5_async_clear", rdata1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1 chk("r5_after_release", rdata1, 32'h0);

        // Write then read, and read-enable gating.
        wr(5'd7, 32'hDEAD_BEEF);
        re2 = 1'b1; raddr2 = 5'd7;
        #1 chk("r7_read", rdata2, 32'hDEAD_BEEF);
        re2 = 1'b0;
        #1 chk("r7_re_off", rdata2, 32'h0);

        // r0 stays zero even when written.
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        #1 chk("r0_same_p1", rdata1, 32'h0);
        chk("r0_same_p2", rdata2, 32'h0);
        @(posedge clk); #1;
        we = 1'b0;
        #1 chk("r0_after_p1", rdata1, 32'h0);
        chk("r0_after_p2", rdata2, 32'h0);

        // Same-cycle write/read hazard on r9.
        wr(5'd9, 32'h1111_1111);
        raddr1 = 5'd9; raddr2 = 5'd9;
        we = 1'b1; waddr = 5'd9; wdata = 32'h2222_2222;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("hazard_pre_p1", rdata1, 32'h2222_2222);
        chk("hazard_pre_p2", rdata2, 32'h2222_2222);
`else
        chk("hazard_pre_p1", rdata1, 32'h1111_1111);
        chk("hazard_pre_p2", rdata2, 32'h1111_1111);
`endif
        @(posedge clk); #1;
        we = 1'b0;
        #1 chk("hazard_post_p1", rdata1, 32'h2222_2222);
        chk("hazard_post_p2", rdata2, 32'h2222_2222);

        // Independent ports.
        wr(5'd3, 32'h0000_000A);
        wr(5'd4, 32'h0000_000B);
        raddr1 = 5'd3; raddr2 = 5'd4;
        #1 chk("dual_p1", rdata1, 32'h0000_000A);
        chk("dual_p2", rdata2, 32'h0000_000B);
        wr(5'd4, 32'h0000_000C);
        #1 chk("dual_upd_p1", rdata1, 32'h0000_000A);
        chk("dual_upd_p2", rdata2, 32'h0000_000C);

        // Sweep all registers.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1 chk("sweep_p1", rdata1, 32'(i) * 32'h0101_0101);
            chk("sweep_p2", rdata2, 32'(31 - i) * 32'h0101_0101);
            @(posedge clk); #1;
        end

        // Reset held across an edge blocks the write.
        we = 1'b1; waddr = 5'd12; wdata = 32'hCAFE_F00D; raddr1 = 5'd12;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        we = 1'b0; rst = 1'b1;
        #1 chk("reset_blocks_write", rdata1, 32'h0);
        @(posedge clk); #1;
        chk("reset_blocks_write_later", rdata1, 32'h0);

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
